// File: rtl/uart_verici_param.sv
// Runtime-configurable UART transmitter: pulls bytes from a TX FIFO and
// serialises start / N data bits (LSB first) / optional parity / 1-2 stop bits.
module uart_verici_param #(
  parameter int VERI_W   = 8,
  parameter int BAUD_W   = 16,
  parameter int BITSAY_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tx_en_i,
  input  logic                veri_gecerli_i,
  output logic                consume_o,
  input  logic [VERI_W-1:0]   gelen_veri_i,
  input  logic [BAUD_W-1:0]   baud_div_i,
  input  logic [BITSAY_W-1:0] veri_bit_i,
  input  logic [1:0]          parite_i,
  input  logic                dur_bit_i,
  output logic                tx_o,
  output logic                hazir_o,
  output logic                mesgul_o
);

  typedef enum logic [2:0] {BOSTA, BASLA, VERI, PARITE, DUR} durum_t;

  localparam logic [BITSAY_W-1:0] LP_VERI_W = BITSAY_W'(VERI_W);
  localparam logic [BITSAY_W-1:0] LP_BIR    = BITSAY_W'(1);

  durum_t              r_durum, w_durum_n;
  logic [BAUD_W-1:0]   r_sayac, w_sayac_n, r_baud;
  logic [BITSAY_W-1:0] r_idx, w_idx_n, r_nbit, w_nbit;
  logic [VERI_W-1:0]   r_kay, w_kay_n, w_maske;
  logic                r_par_en, r_par_bit, r_dur2, r_tx;
  logic                w_tx_n, w_par_n, w_bit_son, w_cerceve_son, w_kabul;

  // Out-of-range bit counts (0 or above VERI_W) fall back to a full word.
  always_comb begin
    w_nbit = veri_bit_i;
    if (veri_bit_i == '0 || veri_bit_i > LP_VERI_W) w_nbit = LP_VERI_W;
    w_maske = '0;
    for (int k = 0; k < VERI_W; k++) w_maske[k] = (k < int'(w_nbit));
    w_par_n = (^(gelen_veri_i & w_maske)) ^ (parite_i == 2'b10);
  end

  // FIFO handshake: a word is taken in exactly the cycles where consume_o is
  // high, i.e. tx_en_i && veri_gecerli_i while idle or in the frame-end cycle.
  assign w_bit_son     = (r_sayac == r_baud);
  assign w_cerceve_son = (r_durum == DUR) && w_bit_son &&
                         (r_idx == (r_dur2 ? LP_BIR : '0));
  assign w_kabul       = tx_en_i && veri_gecerli_i && !rst_i &&
                         ((r_durum == BOSTA) || w_cerceve_son);

  always_comb begin
    w_durum_n = r_durum;
    w_sayac_n = w_bit_son ? '0 : r_sayac + BAUD_W'(1);
    w_idx_n   = r_idx;
    w_kay_n   = r_kay;
    case (r_durum)
      BOSTA: begin
        w_sayac_n = '0;
        if (w_kabul) w_durum_n = BASLA;
      end
      BASLA: begin
        if (w_bit_son) begin
          w_durum_n = VERI;
          w_idx_n   = '0;
        end
      end
      VERI: begin
        if (w_bit_son) begin
          w_kay_n = r_kay >> 1;
          if (r_idx == r_nbit - LP_BIR) begin
            w_durum_n = r_par_en ? PARITE : DUR;
            w_idx_n   = '0;
          end else begin
            w_idx_n = r_idx + LP_BIR;
          end
        end
      end
      PARITE: begin
        if (w_bit_son) begin
          w_durum_n = DUR;
          w_idx_n   = '0;
        end
      end
      DUR: begin
        if (w_cerceve_son) begin
          w_durum_n = w_kabul ? BASLA : BOSTA;
          w_idx_n   = '0;
        end else if (w_bit_son) begin
          w_idx_n = r_idx + LP_BIR;
        end
      end
      default: w_durum_n = BOSTA;
    endcase
    if (w_kabul) w_kay_n = gelen_veri_i;

    // Line value is derived from the next state so tx_o lines up with r_durum.
    case (w_durum_n)
      BASLA:   w_tx_n = 1'b0;
      VERI:    w_tx_n = w_kay_n[0];
      PARITE:  w_tx_n = r_par_bit;
      default: w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum   <= BOSTA;
      r_sayac   <= '0;
      r_idx     <= '0;
      r_kay     <= '0;
      r_baud    <= '0;
      r_nbit    <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_dur2    <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_durum <= w_durum_n;
      r_sayac <= w_sayac_n;
      r_idx   <= w_idx_n;
      r_kay   <= w_kay_n;
      r_tx    <= w_tx_n;
      if (w_kabul) begin
        r_baud    <= baud_div_i;
        r_nbit    <= w_nbit;
        r_par_en  <= (parite_i == 2'b01) || (parite_i == 2'b10);
        r_par_bit <= w_par_n;
        r_dur2    <= dur_bit_i;
      end
    end
  end

  assign consume_o = w_kabul;
  assign hazir_o   = w_cerceve_son;
  assign mesgul_o  = (r_durum != BOSTA);
  assign tx_o      = r_tx;

endmodule

// File: tb/tb_uart_verici_param.sv
// Bench for uart_verici_param: a cycle-level frame model predicts the line,
// FIFO pops, frame-end pulses and busy flag; a monitor compares every cycle.
module tb_uart_verici_param;

  localparam int VERI_W   = 8;
  localparam int BAUD_W   = 16;
  localparam int BITSAY_W = 4;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                tx_en_i = 1'b0;
  logic                veri_gecerli_i = 1'b0;
  logic                consume_o;
  logic [VERI_W-1:0]   gelen_veri_i = '0;
  logic [BAUD_W-1:0]   baud_div_i = '0;
  logic [BITSAY_W-1:0] veri_bit_i = '0;
  logic [1:0]          parite_i = '0;
  logic                dur_bit_i = 1'b0;
  logic                tx_o, hazir_o, mesgul_o;

  uart_verici_param #(.VERI_W(VERI_W), .BAUD_W(BAUD_W), .BITSAY_W(BITSAY_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tx_en_i(tx_en_i), .veri_gecerli_i(veri_gecerli_i),
    .consume_o(consume_o), .gelen_veri_i(gelen_veri_i), .baud_div_i(baud_div_i),
    .veri_bit_i(veri_bit_i), .parite_i(parite_i), .dur_bit_i(dur_bit_i),
    .tx_o(tx_o), .hazir_o(hazir_o), .mesgul_o(mesgul_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic skip;
    logic consume;
    logic hazir;
    logic mesgul;
    logic tx;
  } beklenen_t;

  beklenen_t         exp_q[$];
  logic              line_q[$];   // expected tx_o, one entry per future cycle
  logic [VERI_W-1:0] fifo[$];
  int                n_checks = 0;
  int                n_fail = 0;
  int                hazir_cnt = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Frame built straight from the frame-format rules.
  task automatic build_frame(input logic [VERI_W-1:0] d, input int div, input int vb,
                             input int par, input int stop2);
    int p, n, ones;
    p = div + 1;
    n = (vb >= 1 && vb <= VERI_W) ? vb : VERI_W;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    for (int c = 0; c < p; c++) line_q.push_back(1'b0);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < p; c++) line_q.push_back(d[i]);
    if (par == 1 || par == 2)
      for (int c = 0; c < p; c++) line_q.push_back(par == 1 ? (ones % 2 == 1) : (ones % 2 == 0));
    for (int c = 0; c < p * (stop2 ? 2 : 1); c++) line_q.push_back(1'b1);
  endtask

  // ---------------- reference model ----------------
  initial begin : model
    beklenen_t rec;
    int        sz;
    logic      acc;
    forever begin
      @(negedge clk_i);
      rec = '0;
      if (rst_i) begin
        line_q.delete();
        rec.skip = 1'b1;
      end else begin
        sz  = line_q.size();
        acc = (sz <= 1) && tx_en_i && veri_gecerli_i;
        rec.consume = acc;
        rec.hazir   = (sz == 1);
        rec.mesgul  = (sz > 0);
        rec.tx      = (sz > 0) ? line_q[0] : 1'b1;
        if (sz > 0) void'(line_q.pop_front());
        if (acc) build_frame(gelen_veri_i, int'(baud_div_i), int'(veri_bit_i),
                             int'(parite_i), int'(dur_bit_i));
      end
      exp_q.push_back(rec);
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    beklenen_t r;
    forever begin
      @(negedge clk_i);
      #1;
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        if (!r.skip) begin
          check("tx_o", tx_o, r.tx);
          check("consume_o", consume_o, r.consume);
          check("hazir_o", hazir_o, r.hazir);
          check("mesgul_o", mesgul_o, r.mesgul);
          if (hazir_o) hazir_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic refresh_fifo();
    veri_gecerli_i = (fifo.size() > 0);
    gelen_veri_i   = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  task automatic tick(input int n);
    logic c;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      c = consume_o;
      @(posedge clk_i);
      #1;
      if (c && fifo.size() > 0) void'(fifo.pop_front());
      refresh_fifo();
    end
  endtask

  task automatic push_word(input logic [VERI_W-1:0] d);
    fifo.push_back(d);
    refresh_fifo();
  endtask

  task automatic set_cfg(input int div, input int vb, input int par, input int stop2);
    baud_div_i = BAUD_W'(div);
    veri_bit_i = BITSAY_W'(vb);
    parite_i   = 2'(par);
    dur_bit_i  = (stop2 != 0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((fifo.size() > 0 || line_q.size() > 0) && k < budget) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s timeout: fifo=%0d line=%0d after %0d cycles", name, fifo.size(),
               line_q.size(), k);
    end
    tick(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int h0;
    tick(3);
    rst_i = 1'b0;
    tick(2);

    // 0xA5, P=4, 8N1
    set_cfg(3, 8, 0, 0);
    push_word(8'hA5);
    tx_en_i = 1'b1;
    wait_idle("t1", 200);

    // 7 bits even parity, two stops, P=1
    set_cfg(0, 7, 1, 1);
    push_word(8'h03);
    wait_idle("t2a", 100);
    push_word(8'h07);
    wait_idle("t2b", 100);

    // odd parity, 5 bits, upper bits ignored
    set_cfg(1, 5, 2, 0);
    push_word(8'hFF);
    wait_idle("t3", 100);

    // back-to-back frames
    set_cfg(2, 8, 1, 0);
    h0 = hazir_cnt;
    push_word(8'h12);
    push_word(8'h34);
    push_word(8'h56);
    wait_idle("t4", 500);
    check("t4_hazir_count", (hazir_cnt - h0) == 3, 1'b1);

    // baud change mid-frame
    set_cfg(3, 8, 0, 0);
    push_word(8'h3C);
    push_word(8'hC3);
    tick(6);
    set_cfg(9, 8, 0, 0);
    wait_idle("t5", 500);

    // reset mid data bits
    set_cfg(3, 8, 0, 0);
    push_word(8'h5A);
    tick(10);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    tick(6);

    // enable dropped mid-frame: frame completes, second word stays queued
    push_word(8'h81);
    push_word(8'h7E);
    tick(3);
    tx_en_i = 1'b0;
    tick(60);
    check("t6_word_held", fifo.size() == 1, 1'b1);
    tx_en_i = 1'b1;
    wait_idle("t6", 200);

    // randomized frames and mid-frame disturbances
    for (int it = 0; it < 25; it++) begin
      set_cfg($urandom_range(0, 5), $urandom_range(0, 15), $urandom_range(0, 3),
              $urandom_range(0, 1));
      for (int w = 0; w < int'($urandom_range(1, 3)); w++) push_word(8'($urandom));
      tx_en_i = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        tick($urandom_range(1, 30));
        set_cfg($urandom_range(0, 5), $urandom_range(0, 15), $urandom_range(0, 3),
                $urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) begin
        tick($urandom_range(1, 20));
        tx_en_i = 1'b0;
        tick($urandom_range(10, 80));
        tx_en_i = 1'b1;
      end
      wait_idle("rand", 3000);
    end

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
